// File: rtl/qbus_dma_master.sv
// Qbus DMA master sequencer: arbitrates for the bus, then runs a block of DATI or DATO word cycles.
// Optional build macro QDMA_BURST_LIMIT_EN: give the bus up for one cycle after every 4 transfers.
module qbus_dma_master #(
  parameter int T_ADDR      = 4,
  parameter int T_DESKEW    = 2,
  parameter int T_HOLD      = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        RSTN,
  input  logic        start,
  input  logic        dir_write,
  input  logic [21:0] start_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        BDMGIf,
  input  logic        BSYNCf,
  input  logic        BRPLYf,
  input  logic        BINITf,
  input  logic [21:0] BDALf_IN,
  output logic        BDMRg,
  output logic        BSACKg,
  output logic        BSYNCg,
  output logic        BDINg,
  output logic        BDOUTg,
  output logic        BWTBTg,
  output logic [21:0] BDALf_OUT,
  output logic [21:0] BDALf_OE,
  output logic        Outbound
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_GRANT, S_ADDR, S_SYNC, S_SETUP, S_DATA,
    S_END, S_HOLD, S_NEXT, S_RELEASE, S_REARB, S_ERR
  } state_t;

  localparam logic [15:0] ADDR_LAST   = 16'(T_ADDR - 1);
  localparam logic [15:0] DESKEW_LAST = 16'(T_DESKEW - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(T_HOLD - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [21:0] addr;
  logic [15:0] count;
  logic        dir;
  logic [15:0] wdata;
  logic [15:0] rd_q;
  logic        rd_vld_q;
  logic        done_q;
  logic        err_q;
`ifdef QDMA_BURST_LIMIT_EN
  logic [1:0]  burst;
`endif

  logic [3:0]  sync_q [SYNC_STAGES];
  logic        dmg_s, sync_s, rply_s, init_s;
  logic        abort, first_setup;
  logic        drive_addr, drive_data;
  logic        unused_inputs;

  // Receiver synchronisers; all four lines idle high (negated)
  always_ff @(posedge clock or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
    end else begin
      sync_q[0] <= {BINITf, BRPLYf, BSYNCf, BDMGIf};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign dmg_s  = sync_q[SYNC_STAGES-1][0];
  assign sync_s = sync_q[SYNC_STAGES-1][1];
  assign rply_s = sync_q[SYNC_STAGES-1][2];
  assign init_s = sync_q[SYNC_STAGES-1][3];

  assign unused_inputs = ^{BDALf_IN[21:16], start_addr[0]};

  assign abort = !init_s && (state != S_IDLE) && (state != S_RELEASE) && (state != S_ERR);
  assign first_setup = (state == S_SETUP) && (cnt == 16'd0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start && init_s && word_count != 16'd0) state_nx = S_REQ;
      S_REQ:     if (!dmg_s && sync_s && rply_s) state_nx = S_GRANT;
      S_GRANT:   state_nx = S_ADDR;
      S_ADDR:    if (cnt >= ADDR_LAST && (!dir || wr_valid)) state_nx = S_SYNC;
      S_SYNC:    if (cnt >= DESKEW_LAST) state_nx = S_SETUP;
      S_SETUP:   if (cnt >= DESKEW_LAST) state_nx = S_DATA;
      S_DATA: begin
        if (!rply_s)               state_nx = S_END;
        else if (cnt >= TMO_LAST)  state_nx = S_ERR;
      end
      S_END: begin
        if (rply_s)                state_nx = S_HOLD;
        else if (cnt >= TMO_LAST)  state_nx = S_ERR;
      end
      S_HOLD:    if (cnt >= HOLD_LAST) state_nx = S_NEXT;
      S_NEXT: begin
        if (count == 16'd1)        state_nx = S_RELEASE;
`ifdef QDMA_BURST_LIMIT_EN
        else if (burst == 2'd3)    state_nx = S_REARB;
`endif
        else                       state_nx = S_ADDR;
      end
      S_REARB:   state_nx = S_REQ;
      S_RELEASE: state_nx = S_IDLE;
      S_ERR:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    // Bus INIT overrides every transition
    if (!init_s) state_nx = S_IDLE;
  end

  always_ff @(posedge clock or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr     <= '0;
      count    <= '0;
      dir      <= 1'b0;
      wdata    <= '0;
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef QDMA_BURST_LIMIT_EN
      burst    <= '0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= (state_nx != state) ? 16'd0 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      if (state == S_IDLE && start && init_s) begin
        err_q <= 1'b0;
        if (word_count == 16'd0) begin
          done_q <= 1'b1;
        end else begin
          addr  <= {start_addr[21:1], 1'b0};
          count <= word_count;
          dir   <= dir_write;
`ifdef QDMA_BURST_LIMIT_EN
          burst <= '0;
`endif
        end
      end
      if (first_setup && dir) wdata <= wr_data;
      if (state == S_DATA && !rply_s && !dir && init_s) begin
        rd_q     <= ~BDALf_IN[15:0];
        rd_vld_q <= 1'b1;
      end
      if (state == S_NEXT && init_s) begin
        addr  <= addr + 22'd2;
        count <= count - 16'd1;
`ifdef QDMA_BURST_LIMIT_EN
        burst <= burst + 2'd1;
`endif
      end
      if (state == S_ERR) err_q <= 1'b1;
      if (abort) begin
        err_q  <= 1'b1;
        done_q <= 1'b1;
      end
    end
  end

  // Output decode; every drive is forced off while bus INIT is asserted
  assign drive_addr = (state == S_ADDR) || (state == S_SYNC);
  assign drive_data = dir && ((state == S_SETUP) || (state == S_DATA) ||
                              (state == S_END)   || (state == S_HOLD));

  always_comb begin
    BDMRg     = init_s && (state == S_REQ);
    BSACKg    = init_s && (state inside {S_GRANT, S_ADDR, S_SYNC, S_SETUP, S_DATA,
                                         S_END, S_HOLD, S_NEXT});
    BSYNCg    = init_s && (state inside {S_SYNC, S_SETUP, S_DATA, S_END, S_HOLD});
    BDINg     = init_s && (state == S_DATA) && !dir;
    BDOUTg    = init_s && (state == S_DATA) && dir;
    BWTBTg    = init_s && drive_addr && dir;
    Outbound  = init_s && (drive_addr || drive_data);
    BDALf_OE  = {22{Outbound}};
    BDALf_OUT = '0;
    if (init_s && drive_addr)
      BDALf_OUT = addr;
    else if (init_s && drive_data)
      BDALf_OUT = {6'b0, (first_setup ? wr_data : wdata)};
    wr_ready  = init_s && first_setup && dir;
    rd_valid  = init_s && rd_vld_q;
    rd_data   = init_s ? rd_q : 16'd0;
    busy      = init_s && (state != S_IDLE) && (state != S_RELEASE) && (state != S_ERR);
    done      = done_q || (state == S_RELEASE) || (state == S_ERR);
    error     = err_q;
  end

endmodule

// File: tb/tb_qbus_dma_master.sv
// Randomised bench for qbus_dma_master: emulates the Qbus arbiter and a memory slave, and
// compares observed bus cycles against an address/data list built from the command.
module tb_qbus_dma_master;
  localparam int TO = 200;
  localparam int SS = 2;

  logic        clock = 1'b0;
  logic        RSTN;
  logic        start, dir_write;
  logic [21:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done, error;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        BDMGIf, BSYNCf, BRPLYf, BINITf;
  logic [21:0] BDALf_IN;
  logic        BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg;
  logic [21:0] BDALf_OUT, BDALf_OE;
  logic        Outbound;

  always #5 clock = ~clock;

  qbus_dma_master #(.TIMEOUT_CYC(TO), .SYNC_STAGES(SS)) dut (
    .clock(clock), .RSTN(RSTN), .start(start), .dir_write(dir_write),
    .start_addr(start_addr), .word_count(word_count), .busy(busy), .done(done),
    .error(error), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .BDMGIf(BDMGIf), .BSYNCf(BSYNCf),
    .BRPLYf(BRPLYf), .BINITf(BINITf), .BDALf_IN(BDALf_IN), .BDMRg(BDMRg),
    .BSACKg(BSACKg), .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg),
    .BWTBTg(BWTBTg), .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE), .Outbound(Outbound)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave memory contents: one fixed register, everything else derived from the address
  function automatic logic [15:0] mem_word(input logic [21:0] a);
    if (a == 22'o17772150) return 16'h1234;
    return a[16:1] ^ 16'hC3A5;
  endfunction

  function automatic logic [7:0] g_bits();
    return {BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BWTBTg, Outbound, |BDALf_OE};
  endfunction

  // Bus monitor
  logic [21:0] q_addr[$];
  logic [21:0] q_wdat[$];
  logic [15:0] q_rd[$];
  int          done_cnt, wrr_cnt, sack_drop;
  logic        dmr_seen;
  logic        m_sync, m_dout, m_din, m_sack;

  task automatic clear_mon();
    q_addr.delete(); q_wdat.delete(); q_rd.delete();
    done_cnt = 0; wrr_cnt = 0; sack_drop = 0; dmr_seen = 1'b0;
  endtask

  initial begin
    m_sync = 1'b0; m_dout = 1'b0; m_din = 1'b0; m_sack = 1'b0;
    clear_mon();
    forever begin
      @(negedge clock);
      if (BSYNCg && !m_sync) begin
        q_addr.push_back(BDALf_OUT);
        check_eq("oe_at_sync", 32'(BDALf_OE), 32'h3FFFFF);
      end
      if (BDOUTg && !m_dout) q_wdat.push_back(BDALf_OUT);
      if (BDINg && !m_din) check_eq("oe_at_din", 32'({Outbound, BDALf_OE}), 32'd0);
      if (rd_valid) q_rd.push_back(rd_data);
      if (done) done_cnt++;
      if (wr_ready) wrr_cnt++;
      if (!BSACKg && m_sack) sack_drop++;
      if (BDMRg) dmr_seen = 1'b1;
      m_sync = BSYNCg; m_dout = BDOUTg; m_din = BDINg; m_sack = BSACKg;
    end
  end

  // Arbiter: grant some cycles after a request, withdraw once the master acknowledges
  initial begin
    BDMGIf = 1'b1;
    forever begin
      @(negedge clock);
      if (BDMRg) begin
        int n;
        repeat ($urandom_range(0, 3)) @(negedge clock);
        BDMGIf = 1'b0;
        n = 0;
        while (!BSACKg && n < 50) begin @(negedge clock); n++; end
        BDMGIf = 1'b1;
      end
    end
  end

  // Memory slave
  logic        slave_en;
  logic [21:0] sa;
  logic        s_sync;
  initial begin
    BRPLYf = 1'b1; BDALf_IN = '1; sa = '0; s_sync = 1'b0; slave_en = 1'b1;
    forever begin
      @(negedge clock);
      if (BSYNCg && !s_sync) sa = BDALf_OUT;
      s_sync = BSYNCg;
      if (slave_en && (BDINg || BDOUTg)) begin
        int n;
        repeat ($urandom_range(0, 3)) @(negedge clock);
        BDALf_IN = ~{6'b0, mem_word(sa)};
        BRPLYf = 1'b0;
        n = 0;
        while ((BDINg || BDOUTg) && n < 5000) begin @(negedge clock); n++; end
        repeat ($urandom_range(0, 3)) @(negedge clock);
        BRPLYf = 1'b1;
        BDALf_IN = '1;
        s_sync = BSYNCg;
      end
    end
  end

  logic [15:0] wexp [16];

  task automatic feed(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int n;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      wr_data = wexp[i];
      wr_valid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!wr_ready && n < 5000) begin @(negedge clock); n++; end
      if (!wr_ready) check_eq("wr_ready_timeout", 32'(wr_ready), 32'd1);
      @(negedge clock);
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 20000) begin @(negedge clock); cyc++; end
    if (!done) check_eq({tag, " done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_start(input logic dir, input logic [21:0] a, input int cnt);
    start_addr = a; dir_write = dir; word_count = 16'(cnt);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic dir, input logic [21:0] a, input int cnt);
    logic [21:0] ea;
    int cyc, drops;
    for (int i = 0; i < cnt; i++) wexp[i] = 16'($urandom);
    clear_mon();
    pulse_start(dir, a, cnt);
    fork
      if (dir) feed(cnt);
      wait_done(tag, cyc);
    join
    repeat (6) @(negedge clock);
`ifdef QDMA_BURST_LIMIT_EN
    drops = (cnt + 3) / 4;
`else
    drops = (cnt > 0) ? 1 : 0;
`endif
    check_eq({tag, " n_cycles"}, 32'(q_addr.size()), 32'(cnt));
    ea = {a[21:1], 1'b0};
    for (int i = 0; i < cnt; i++) begin
      if (i < q_addr.size()) check_eq({tag, " addr"}, 32'(q_addr[i]), 32'(ea));
      if (dir && i < q_wdat.size()) check_eq({tag, " wdata"}, 32'(q_wdat[i]), 32'({6'b0, wexp[i]}));
      if (!dir && i < q_rd.size()) check_eq({tag, " rdata"}, 32'(q_rd[i]), 32'(mem_word(ea)));
      ea = ea + 22'd2;
    end
    check_eq({tag, " n_wdata"}, 32'(q_wdat.size()), dir ? 32'(cnt) : 32'd0);
    check_eq({tag, " n_rd_valid"}, 32'(q_rd.size()), dir ? 32'd0 : 32'(cnt));
    check_eq({tag, " n_wr_ready"}, 32'(wrr_cnt), dir ? 32'(cnt) : 32'd0);
    check_eq({tag, " n_done"}, 32'(done_cnt), 32'd1);
    check_eq({tag, " sack_drops"}, 32'(sack_drop), 32'(drops));
    check_eq({tag, " end_state"}, 32'({error, busy, BSACKg}), 32'd0);
    if (cnt == 0) check_eq({tag, " no_dmr"}, 32'(dmr_seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc, k;
    logic dir;
    logic [21:0] a;
    RSTN = 1'b0; start = 1'b0; dir_write = 1'b0; start_addr = '0; word_count = '0;
    wr_data = '0; wr_valid = 1'b0; BSYNCf = 1'b1; BINITf = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("reset ctl", 32'({busy, done, error, wr_ready, rd_valid}), 32'd0);
    check_eq("reset g", 32'(g_bits()), 32'd0);
    check_eq("reset bdal", 32'(BDALf_OUT), 32'd0);
    RSTN = 1'b1;
    repeat (3) @(negedge clock);

    run_cmd("dati_csr", 1'b0, 22'o17772150, 1);
    if (q_rd.size() > 0) check_eq("dati_csr value", 32'(q_rd[0]), 32'h1234);
    run_cmd("dato3", 1'b1, 22'h001000, 3);
    run_cmd("wrap", 1'b0, 22'h3FFFFE, 2);
    run_cmd("zero", 1'b1, 22'h000200, 0);
    run_cmd("burst6", 1'b1, 22'h000400, 6);

    // No reply from slave: bus timeout
    slave_en = 1'b0;
    clear_mon();
    pulse_start(1'b0, 22'h000100, 2);
    wait_done("timeout", cyc);
    check_eq("timeout g_off", 32'(g_bits()), 32'd0);
    check_eq("timeout late_enough", 32'(cyc >= TO), 32'd1);
    check_eq("timeout not_too_late", 32'(cyc < TO + 40), 32'd1);
    repeat (5) @(negedge clock);
    check_eq("timeout error", 32'(error), 32'd1);
    check_eq("timeout n_done", 32'(done_cnt), 32'd1);
    check_eq("timeout busy", 32'(busy), 32'd0);

    // Bus INIT in the middle of a DATI data phase
    clear_mon();
    pulse_start(1'b0, 22'h002000, 3);
    k = 0;
    while (!BDINg && k < 1000) begin @(negedge clock); k++; end
    check_eq("init reached_din", 32'(BDINg), 32'd1);
    BINITf = 1'b0;
    k = 0;
    while (g_bits() != 8'd0 && k < 10) begin @(negedge clock); k++; end
    check_eq("init g_off_fast", 32'(k <= SS + 1), 32'd1);
    repeat (5) @(negedge clock);
    check_eq("init error", 32'(error), 32'd1);
    check_eq("init n_done", 32'(done_cnt), 32'd1);
    clear_mon();
    pulse_start(1'b1, 22'h003000, 1);
    repeat (6) @(negedge clock);
    check_eq("init blocks_start", 32'({busy, dmr_seen}), 32'd0);
    check_eq("init blocked_no_done", 32'(done_cnt), 32'd0);
    BINITf = 1'b1;
    slave_en = 1'b1;
    repeat (SS + 3) @(negedge clock);
    run_cmd("after_init", 1'b0, 22'h004000, 2);

    for (int t = 0; t < 10; t++) begin
      dir = 1'($urandom);
      a = 22'($urandom);
      if ($urandom_range(0, 3) == 0) a = 22'h3FFFF8;
      run_cmd($sformatf("rand%0d", t), dir, a, int'($urandom_range(1, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
